// File: rtl/alu_pkg.sv
// Shared ALU unit codes and collector FSM state type.
package alu_pkg;

  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] CMP   = 2'b10;
  localparam logic [1:0] SHIFT = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SEND_LO = 2'b01,
    SEND_HI = 2'b10
  } state_t;

endpackage

// File: rtl/alu_result_collector_if.sv
// Result-collection and TX byte-stream bundle for alu_result_collector.
interface alu_result_collector_if #(parameter int WIDTH = 8);

  logic                 Arith_Valid;
  logic                 Logic_Valid;
  logic                 CMP_Valid;
  logic                 SHIFT_Valid;
  logic [2*WIDTH-1:0]   Arith_Result;
  logic [WIDTH-1:0]     Logic_Result;
  logic [WIDTH-1:0]     CMP_Result;
  logic [WIDTH-1:0]     SHIFT_Result;
  logic                 TX_Ready;

  logic [2*WIDTH-1:0]   ALU_OUT;
  logic                 OUT_Valid;
  logic [1:0]           Unit_Code;
  logic [WIDTH-1:0]     TX_Data;
  logic                 TX_Valid;
  logic                 Busy;
  logic                 Sel_Error;
  logic                 Overrun;

  // Environment side: ALU units and TX sink.
  modport master (
    output Arith_Valid, Logic_Valid, CMP_Valid, SHIFT_Valid,
    output Arith_Result, Logic_Result, CMP_Result, SHIFT_Result,
    output TX_Ready,
    input  ALU_OUT, OUT_Valid, Unit_Code, TX_Data, TX_Valid,
    input  Busy, Sel_Error, Overrun
  );

  // Collector side.
  modport slave (
    input  Arith_Valid, Logic_Valid, CMP_Valid, SHIFT_Valid,
    input  Arith_Result, Logic_Result, CMP_Result, SHIFT_Result,
    input  TX_Ready,
    output ALU_OUT, OUT_Valid, Unit_Code, TX_Data, TX_Valid,
    output Busy, Sel_Error, Overrun
  );

endinterface

// File: rtl/alu_unit_encoder.sv
// Encodes the four one-hot unit valids to a 2-bit unit code with any/multi flags.
module alu_unit_encoder
  import alu_pkg::*;
(
  input  logic       arith_valid,
  input  logic       logic_valid,
  input  logic       cmp_valid,
  input  logic       shift_valid,
  output logic [1:0] code,
  output logic       any,
  output logic       multi
);

  // Code is only meaningful when exactly one valid is set.
  always_comb begin
    code  = {cmp_valid | shift_valid, logic_valid | shift_valid};
    any   = arith_valid | logic_valid | cmp_valid | shift_valid;
    multi = (arith_valid & logic_valid) | (arith_valid & cmp_valid) |
            (arith_valid & shift_valid) | (logic_valid & cmp_valid) |
            (logic_valid & shift_valid) | (cmp_valid & shift_valid);
  end

endmodule

// File: rtl/alu_result_collector.sv
// Collects ALU unit results, registers them with their unit code and streams
// them to the TX path as one byte (logic/cmp/shift) or two bytes (arith).
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic                  CLK,
  input  logic                  RST,
  alu_result_collector_if.slave bus
);

  logic [1:0]         code;
  logic               any;
  logic               multi;
  logic [2*WIDTH-1:0] capture_data;

  state_t             state;
  logic [2*WIDTH-1:0] alu_out;
  logic [1:0]         unit_code;
  logic               out_valid;
  logic               tx_valid;
  logic               sel_error;
  logic               overrun;

  alu_unit_encoder u_encoder (
    .arith_valid (bus.Arith_Valid),
    .logic_valid (bus.Logic_Valid),
    .cmp_valid   (bus.CMP_Valid),
    .shift_valid (bus.SHIFT_Valid),
    .code        (code),
    .any         (any),
    .multi       (multi)
  );

  // Select the result of the reporting unit, zero-extending the narrow ones.
  always_comb begin
    capture_data = '0;
    case (code)
      ARITH:   capture_data = bus.Arith_Result;
      LOGIC:   capture_data = {{WIDTH{1'b0}}, bus.Logic_Result};
      CMP:     capture_data = {{WIDTH{1'b0}}, bus.CMP_Result};
      default: capture_data = {{WIDTH{1'b0}}, bus.SHIFT_Result};
    endcase
  end

  // Capture register, send FSM and error pulse flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      alu_out   <= '0;
      unit_code <= ARITH;
      out_valid <= 1'b0;
      tx_valid  <= 1'b0;
      sel_error <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      sel_error <= multi;
      // The final handshake cycle is still busy, so a valid there is dropped.
      overrun   <= any && (state != IDLE);
      case (state)
        IDLE: begin
          if (any && !multi) begin
            alu_out   <= capture_data;
            unit_code <= code;
            out_valid <= 1'b1;
            tx_valid  <= 1'b1;
            state     <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (bus.TX_Ready) begin
            if (unit_code == ARITH) begin
              state <= SEND_HI;
            end else begin
              state    <= IDLE;
              tx_valid <= 1'b0;
            end
          end
        end
        SEND_HI: begin
          if (bus.TX_Ready) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ALU_OUT   = alu_out;
  assign bus.OUT_Valid = out_valid;
  assign bus.Unit_Code = unit_code;
  assign bus.TX_Valid  = tx_valid;
  assign bus.TX_Data   = (state == SEND_HI) ? alu_out[2*WIDTH-1:WIDTH] : alu_out[WIDTH-1:0];
  assign bus.Busy      = (state != IDLE);
  assign bus.Sel_Error = sel_error;
  assign bus.Overrun   = overrun;

endmodule
